// File: rtl/dmem_mmio.sv
// Data-memory stage: word RAM plus an MMIO page (LED, cycle counter, FIFO-fed 8N1 transmitter).
// Reads are combinational; writes, counters and the transmitter advance on the rising clock edge.
module dmem_mmio #(
  parameter int ADDR_WIDTH = 10,
  parameter int FIFO_DEPTH = 4,
  parameter int CLK_DIV    = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        DM_CS,
  input  logic        DM_R,
  input  logic        DM_W,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        bus_err,
  output logic [7:0]  led,
  output logic        tx
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int DW = $clog2(CLK_DIV);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [31:0]           r_ram [2**ADDR_WIDTH];
  logic [7:0]            r_fifo [FIFO_DEPTH];
  logic [PW-1:0]         r_wptr, r_rptr;
  logic [CW-1:0]         r_cnt;
  logic [31:0]           r_cycles;
  logic                  r_ovf;
  logic [1:0]            r_state;
  logic [DW-1:0]         r_div;
  logic [2:0]            r_bit;
  logic [7:0]            r_sh;

  logic                  w_is_ram, w_is_led, w_is_cyc, w_is_txd, w_is_stat;
  logic                  w_mapped, w_misal, w_rd_ok, w_wr_ok;
  logic                  w_full, w_empty, w_busy, w_push, w_pop, w_div_end, w_shift;
  logic [ADDR_WIDTH-1:0] w_idx;

  assign w_is_ram  = (addr[31:28] == 4'h0);
  assign w_is_led  = (addr == 32'hFFFF_0000);
  assign w_is_cyc  = (addr == 32'hFFFF_0004);
  assign w_is_txd  = (addr == 32'hFFFF_0008);
  assign w_is_stat = (addr == 32'hFFFF_000C);
  assign w_mapped  = w_is_ram | w_is_led | w_is_cyc | w_is_txd | w_is_stat;
  assign w_misal   = (addr[1:0] != 2'b00);
  assign w_idx     = addr[ADDR_WIDTH+1:2];
  assign bus_err   = DM_CS & (DM_R | DM_W) & (w_misal | ~w_mapped);
  assign w_rd_ok   = DM_CS & DM_R & ~w_misal & w_mapped;
  assign w_wr_ok   = DM_CS & DM_W & ~w_misal & w_mapped;

  assign w_full    = (r_cnt == CW'(FIFO_DEPTH));
  assign w_empty   = (r_cnt == '0);
  assign w_busy    = (r_state != S_IDLE);
  assign w_div_end = (r_div == DW'(CLK_DIV - 1));
  assign w_push    = w_wr_ok & w_is_txd & ~w_full;
  // Pop on leaving IDLE, or at the end of a stop bit so frames chain with no idle gap.
  assign w_pop     = ~w_empty & ((r_state == S_IDLE) | ((r_state == S_STOP) & w_div_end));
  assign w_shift   = w_div_end & ((r_state == S_START) | ((r_state == S_DATA) & (r_bit != 3'd7)));

  always_comb begin
    rdata = '0;
    if (w_rd_ok) begin
      if (w_is_ram)       rdata = r_ram[w_idx];
      else if (w_is_led)  rdata = {24'b0, led};
      else if (w_is_cyc)  rdata = r_cycles;
      else if (w_is_stat) rdata = {28'b0, r_ovf, w_busy, w_empty, w_full};
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_ok & w_is_ram) r_ram[w_idx] <= wdata;
    if (w_push) r_fifo[r_wptr] <= wdata[7:0];
    if (w_pop) r_sh <= r_fifo[r_rptr];
    else if (w_shift) r_sh <= r_sh >> 1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      led      <= '0;
      r_cycles <= '0;
      r_ovf    <= 1'b0;
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_cnt    <= '0;
    end else begin
      if (w_wr_ok & w_is_led) led <= wdata[7:0];
      r_cycles <= (w_wr_ok & w_is_cyc) ? '0 : r_cycles + 32'd1;
      // A dropped push sets overflow even if STATUS clears it on the same edge.
      if (w_wr_ok & w_is_txd & w_full) r_ovf <= 1'b1;
      else if (w_wr_ok & w_is_stat & wdata[3]) r_ovf <= 1'b0;
      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop)  r_rptr <= r_rptr + PW'(1);
      if (w_push & ~w_pop)      r_cnt <= r_cnt + CW'(1);
      else if (~w_push & w_pop) r_cnt <= r_cnt - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_div   <= '0;
      r_bit   <= '0;
      tx      <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          tx    <= 1'b1;
          r_div <= '0;
          if (!w_empty) begin
            r_state <= S_START;
            tx      <= 1'b0;
          end
        end
        S_START: begin
          if (w_div_end) begin
            r_div   <= '0;
            r_bit   <= '0;
            r_state <= S_DATA;
            tx      <= r_sh[0];
          end else r_div <= r_div + DW'(1);
        end
        S_DATA: begin
          if (w_div_end) begin
            r_div <= '0;
            if (r_bit == 3'd7) begin
              r_state <= S_STOP;
              tx      <= 1'b1;
            end else begin
              r_bit <= r_bit + 3'd1;
              tx    <= r_sh[0];
            end
          end else r_div <= r_div + DW'(1);
        end
        default: begin
          if (w_div_end) begin
            r_div <= '0;
            if (!w_empty) begin
              r_state <= S_START;
              tx      <= 1'b0;
            end else begin
              r_state <= S_IDLE;
              tx      <= 1'b1;
            end
          end else r_div <= r_div + DW'(1);
        end
      endcase
    end
  end

endmodule
